// File: rtl/flex_counter.sv
// Parameterized up-counter with a programmable rollover value and a registered rollover flag.
// Both outputs come straight from flops; the flag is precomputed from the next count.
module flex_counter #(
    parameter int unsigned NUM_CNT_BITS = 4
) (
    input  logic                    CLK,
    input  logic                    n_rst,
    input  logic                    clear,
    input  logic                    count_enable,
    input  logic [NUM_CNT_BITS-1:0] rollover_val,
    output logic [NUM_CNT_BITS-1:0] count_out,
    output logic                    rollover_flag
);

    logic [NUM_CNT_BITS-1:0] count_q, count_d;
    logic                    flag_q, flag_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (count_enable) begin
            if (count_q == rollover_val) begin
                count_d = NUM_CNT_BITS'(1);
            end else begin
                count_d = count_q + NUM_CNT_BITS'(1);
            end
        end
    end

    // Flag compares the next count against the current rollover_val so it
    // rises on the same edge the count reaches rollover_val.
    always_comb begin
        flag_d = 1'b0;
        if (!clear) begin
            flag_d = (count_d == rollover_val);
        end
    end

    always_ff @(posedge CLK or negedge n_rst) begin
        if (!n_rst) begin
            count_q <= '0;
            flag_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            flag_q  <= flag_d;
        end
    end

    assign count_out     = count_q;
    assign rollover_flag = flag_q;

endmodule

// File: tb/tb_flex_counter.sv
// Directed self-checking bench for flex_counter (NUM_CNT_BITS = 4).
module tb_flex_counter;

    logic       CLK;
    logic       n_rst;
    logic       clear;
    logic       count_enable;
    logic [3:0] rollover_val;
    logic [3:0] count_out;
    logic       rollover_flag;

    int checks;
    int errors;

    flex_counter #(.NUM_CNT_BITS(4)) dut (
        .CLK          (CLK),
        .n_rst        (n_rst),
        .clear        (clear),
        .count_enable (count_enable),
        .rollover_val (rollover_val),
        .count_out    (count_out),
        .rollover_flag(rollover_flag)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic       clr;
        logic       en;
        logic [3:0] rv;
        logic [3:0] exp_cnt;
        logic       exp_flag;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [3:0] ec, input logic ef);
        checks++;
        if (count_out !== ec || rollover_flag !== ef) begin
            errors++;
            $display("FAIL %s: got count_out=%0d flag=%0b, expected count_out=%0d flag=%0b",
                     name, count_out, rollover_flag, ec, ef);
        end
    endtask

    // Drive inputs after the falling edge, sample 1 time unit after the rising edge.
    task automatic cyc(input logic clr, input logic en, input logic [3:0] rv);
        @(negedge CLK);
        clear        = clr;
        count_enable = en;
        rollover_val = rv;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        n_rst        = 1'b0;
        clear        = 1'b0;
        count_enable = 1'b0;
        rollover_val = 4'd5;
        #1;
        check("reset_state", 4'd0, 1'b0);

        // Release reset with nothing active: outputs must not move.
        @(negedge CLK);
        n_rst = 1'b1;
        @(posedge CLK);
        #1;
        check("reset_release_idle", 4'd0, 1'b0);

        //            clr   en    rv     cnt    flag
        tbl.push_back('{1'b0, 1'b1, 4'd5, 4'd1, 1'b0});  // normal rollover
        tbl.push_back('{1'b0, 1'b1, 4'd5, 4'd2, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 4'd5, 4'd3, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 4'd5, 4'd4, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 4'd5, 4'd5, 1'b1});
        tbl.push_back('{1'b0, 1'b1, 4'd5, 4'd1, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 4'd5, 4'd2, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 4'd5, 4'd3, 1'b0});  // run up to 5 again
        tbl.push_back('{1'b0, 1'b1, 4'd5, 4'd4, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 4'd5, 4'd5, 1'b1});
        tbl.push_back('{1'b0, 1'b0, 4'd5, 4'd5, 1'b1});  // hold at rollover
        tbl.push_back('{1'b0, 1'b0, 4'd5, 4'd5, 1'b1});
        tbl.push_back('{1'b0, 1'b0, 4'd5, 4'd5, 1'b1});
        tbl.push_back('{1'b0, 1'b1, 4'd5, 4'd1, 1'b0});  // re-enable wraps
        tbl.push_back('{1'b0, 1'b1, 4'd5, 4'd2, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 4'd5, 4'd3, 1'b0});
        tbl.push_back('{1'b1, 1'b1, 4'd5, 4'd0, 1'b0});  // clear beats enable
        tbl.push_back('{1'b0, 1'b1, 4'd5, 4'd1, 1'b0});
        tbl.push_back('{1'b0, 1'b0, 4'd1, 4'd1, 1'b1});  // rv change while holding
        tbl.push_back('{1'b0, 1'b0, 4'd4, 4'd1, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 4'd1, 4'd1, 1'b1});  // rv=1 sticks at 1
        tbl.push_back('{1'b0, 1'b1, 4'd1, 4'd1, 1'b1});
        tbl.push_back('{1'b1, 1'b0, 4'd1, 4'd0, 1'b0});  // plain clear
        tbl.push_back('{1'b0, 1'b0, 4'd0, 4'd0, 1'b1});
        tbl.push_back('{1'b0, 1'b1, 4'd0, 4'd1, 1'b0});

        for (int i = 0; i < tbl.size(); i++) begin
            cyc(tbl[i].clr, tbl[i].en, tbl[i].rv);
            check($sformatf("vec%0d", i), tbl[i].exp_cnt, tbl[i].exp_flag);
        end

        // Asynchronous reset mid-count, between clock edges.
        cyc(1'b1, 1'b0, 4'd9);
        for (int i = 1; i <= 5; i++) cyc(1'b0, 1'b1, 4'd9);
        check("pre_reset_count5", 4'd5, 1'b0);
        @(negedge CLK);
        #2;
        n_rst = 1'b0;
        #1;
        check("async_reset", 4'd0, 1'b0);
        clear        = 1'b0;
        count_enable = 1'b1;
        @(posedge CLK);
        #1;
        check("reset_overrides_enable", 4'd0, 1'b0);
        @(negedge CLK);
        n_rst        = 1'b1;
        count_enable = 1'b0;
        @(posedge CLK);
        #1;
        check("reset_release_hold", 4'd0, 1'b0);
        cyc(1'b0, 1'b1, 4'd9);
        check("first_enabled_edge", 4'd1, 1'b0);

        // Max rollover value, then drop rollover_val to 0 at count 15.
        cyc(1'b1, 1'b0, 4'd15);
        for (int i = 1; i <= 15; i++) begin
            cyc(1'b0, 1'b1, 4'd15);
            check($sformatf("max_up%0d", i), 4'(i), (i == 15));
        end
        cyc(1'b0, 1'b1, 4'd15);
        check("max_wrap", 4'd1, 1'b0);
        for (int i = 2; i <= 15; i++) cyc(1'b0, 1'b1, 4'd15);
        check("max_again15", 4'd15, 1'b1);
        cyc(1'b0, 1'b1, 4'd0);
        check("rv0_to_zero", 4'd0, 1'b1);
        cyc(1'b0, 1'b1, 4'd0);
        check("rv0_wrap", 4'd1, 1'b0);

        // Drop rollover_val below the current count: wrap through 15 and 0.
        cyc(1'b1, 1'b0, 4'd9);
        for (int i = 1; i <= 7; i++) cyc(1'b0, 1'b1, 4'd9);
        check("drop_pre7", 4'd7, 1'b0);
        for (int i = 8; i <= 19; i++) begin
            logic [3:0] e;
            e = 4'(i);
            cyc(1'b0, 1'b1, 4'd3);
            check($sformatf("drop_step%0d", i), e, (e == 4'd3));
        end
        cyc(1'b0, 1'b1, 4'd3);
        check("drop_wrap", 4'd1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete, expected finish before 100000");
        $fatal(1);
    end

endmodule

// File: doc/flex_counter.md
FLEX_COUNTER -- requirements
Module: flex_counter

Interface
REQ-001 Parameter NUM_CNT_BITS, default 4, SHALL set the counter width in bits, with a legal range of 2..32.
REQ-002 Port CLK, input, 1 bit, SHALL be the single clock; all state SHALL update on its rising edge.
REQ-003 Port n_rst, input, 1 bit, SHALL be the reset: asynchronous, active-low.
REQ-004 Port clear, input, 1 bit, SHALL be a synchronous clear request.
REQ-005 Port count_enable, input, 1 bit, SHALL be the count-advance enable.
REQ-006 Port rollover_val, input, NUM_CNT_BITS, SHALL be the count value at which the counter wraps; it is unsigned and may change on any cycle.
REQ-007 Port count_out, output, NUM_CNT_BITS, SHALL be the registered current count.
REQ-008 Port rollover_flag, output, 1 bit, SHALL be a registered flag that is high while count_out equals rollover_val.

Function
REQ-009 Both outputs SHALL be driven directly from flip-flops, with no combinational path from any input to any output.
REQ-010 next_count SHALL be selected by the first matching condition, in this priority order: clear=1 gives 0.
REQ-011 Otherwise, count_enable=1 and count_out==rollover_val SHALL give next_count=1.
REQ-012 Otherwise, count_enable=1 SHALL give next_count = count_out+1, computed modulo 2^NUM_CNT_BITS.
REQ-013 Otherwise (count_enable=0), next_count SHALL equal count_out, i.e. the count holds.
REQ-014 next_flag SHALL be 0 when clear=1; otherwise next_flag SHALL be (next_count == rollover_val), computed against the current rollover_val.
REQ-015 The flag SHALL therefore rise on the same edge on which count_out becomes rollover_val, with zero extra latency.
REQ-016 The flag SHALL stay high while disabled at rollover_val.
REQ-017 The flag SHALL fall on the edge on which the count wraps to 1.
REQ-018 When clear and count_enable are both 1, clear SHALL win: count_out=0 and rollover_flag=0.
REQ-019 If rollover_val changes while the count holds, rollover_flag SHALL re-evaluate against the new value on the next edge.
REQ-020 If rollover_val is set below the current count_out, the counter SHALL continue incrementing, wrap through 2^NUM_CNT_BITS-1 to 0, and then roll over on reaching rollover_val.
REQ-021 With rollover_val=0, the sequence SHALL be 1, 2, ..., 2^N-1, 0 (flag=1), 1, ...
REQ-022 With rollover_val=1, the count SHALL stay at 1 with the flag continuously high after the first enabled edge.

Reset
REQ-023 n_rst=0 SHALL immediately force count_out=0 and rollover_flag=0, regardless of CLK.
REQ-024 Reset SHALL override clear and count_enable, including when asserted mid-count.
REQ-025 After n_rst deasserts, the first enabled rising edge SHALL produce count_out=1.
REQ-026 The outputs SHALL NOT toggle on the edge at which n_rst deasserts unless clear or count_enable is active on that edge.

Verification
REQ-027 Reset: with count_out=5, assert n_rst=0 between edges -> count_out=0 and flag=0 without waiting for a clock edge.
REQ-028 Normal rollover (N=4, rollover_val=5, enable held 7 cycles) -> count_out 1,2,3,4,5,1,2, with flag high only on the cycle count_out=5.
REQ-029 Hold at rollover (rollover_val=5, count_out=5, count_enable=0 for 3 cycles) -> count_out stays 5 and flag stays 1; re-enabling gives count_out=1 and flag=0.
REQ-030 Clear priority (count_out=3, clear=1 with count_enable=1) -> count_out=0 and flag=0 next edge; the following enabled edge gives 1.
REQ-031 Max rollover (N=4, rollover_val=15) -> sequence reaches 15 with flag=1, then 1; then set rollover_val=0 from count_out=15 while enabled -> next count_out=0 with flag=1, then 1.
REQ-032 Mid-count rollover_val drop (count_out=7, rollover_val changed to 3, enabled) -> count_out 8..15, 0, 1, 2, 3 with flag=1 at 3, then 1.
